// File: rtl/div84.sv
// div84 - sequential 8-bit by 4-bit unsigned restoring divider.
//
// One quotient bit is resolved per clock, MSB first, behind a start/done
// handshake. Q[8] flags a zero divisor (Q = 9'h1FF, R = 0 in that case).
//
// Optional build macro: DIV84_EARLY_EXIT_EN
//   When defined, a zero divisor or a dividend smaller than the divisor is
//   resolved in the capture cycle and the iterations are skipped, so done
//   arrives one edge after start instead of nine. Results are identical in
//   both builds; only the latency differs.
module div84 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] X,
    input  logic [3:0] Y,
    output logic       busy,
    output logic       done,
    output logic [8:0] Q,
    output logic [3:0] R
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;

    // Captured operands; the dividend is consumed MSB first by shifting.
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       div_zero;

    // Partial remainder (one guard bit) and quotient shift register.
    logic [4:0] rem;
    logic [7:0] quo;
    logic [2:0] iter;

    // One restoring step and control decodes.
    logic [4:0] rem_shift;
    logic [4:0] rem_sub;
    logic       take;
    logic       accept;
    logic       last_iter;
    logic       early_exit;

    // Restoring step: bring down the next dividend bit and trial-subtract.
    always_comb begin
        rem_shift = {rem[3:0], dividend[7]};
        take      = (rem_shift >= {1'b0, divisor});
        rem_sub   = rem_shift - {1'b0, divisor};
    end

    // Control decodes. Start is only honoured in IDLE, so pulses while busy
    // or while the result is being published are dropped.
    always_comb begin
        accept    = (state == S_IDLE) && start;
        last_iter = (iter == 3'd7);
`ifdef DIV84_EARLY_EXIT_EN
        early_exit = (Y == 4'd0) || (X < {4'd0, Y});
`else
        early_exit = 1'b0;
`endif
    end

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        // NOTE: the default assignment up front keeps every path assigned,
        // so no latch is inferred for state_nxt.
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = early_exit ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here is small and control-relevant, so all of
        // them take the async reset; a mid-run reset leaves nothing stale.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every
            // register samples the pre-edge values, independent of order.
            state <= state_nxt;
        end
    end

    // Operand capture and the per-clock restoring iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend <= 8'd0;
            divisor  <= 4'd0;
            div_zero <= 1'b0;
            rem      <= 5'd0;
            quo      <= 8'd0;
            iter     <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dividend <= X;
                        divisor  <= Y;
                        div_zero <= (Y == 4'd0);
                        iter     <= 3'd0;
                        quo      <= 8'd0;
                        // With early exit taken for X < Y the answer is
                        // already known: quotient 0, remainder X (fits in 4
                        // bits because X < Y <= 15).
                        if (early_exit && (Y != 4'd0)) begin
                            rem <= {1'b0, X[3:0]};
                        end else begin
                            rem <= 5'd0;
                        end
                    end
                end
                S_RUN: begin
                    dividend <= {dividend[6:0], 1'b0};
                    rem      <= take ? rem_sub : rem_shift;
                    quo      <= {quo[6:0], take};
                    iter     <= iter + 3'd1;
                end
                default: begin
                    // DONE: datapath holds while the result is published.
                end
            endcase
        end
    end

    // Result registers: updated once per operation and held until the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q    <= 9'd0;
            R    <= 4'd0;
            done <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                if (div_zero) begin
                    Q <= 9'h1FF;
                    R <= 4'h0;
                end else begin
                    Q <= {1'b0, quo};
                    R <= rem[3:0];
                end
            end
        end
    end

    // busy covers exactly the iteration cycles; done is only raised after
    // RUN has been left, so the two never overlap.
    assign busy = (state == S_RUN);

endmodule

// File: tb/tb_div84.sv
// tb_div84 - self-checking bench for div84.
// Reference results come from plain integer / and %, with the zero-divisor
// rule applied on top. Latency expectations follow the DIV84_EARLY_EXIT_EN
// build macro when it is defined for the bench as well.
module tb_div84;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] X;
    logic [3:0] Y;
    logic       busy;
    logic       done;
    logic [8:0] Q;
    logic [3:0] R;

    int checks   = 0;
    int failures = 0;

`ifdef DIV84_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam int TIMEOUT = 20;

    div84 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .X     (X),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [8:0] model_q(input logic [7:0] x, input logic [3:0] y);
        int qv;
        if (y == 4'd0) return 9'h1FF;
        qv = int'(x) / int'(y);
        return 9'(qv);
    endfunction

    function automatic logic [3:0] model_r(input logic [7:0] x, input logic [3:0] y);
        int rv;
        if (y == 4'd0) return 4'd0;
        rv = int'(x) % int'(y);
        return 4'(rv);
    endfunction

    function automatic bit model_early(input logic [7:0] x, input logic [3:0] y);
        return EARLY && ((y == 4'd0) || (int'(x) < int'(y)));
    endfunction

    // edges from the start-sampling edge to the edge where done appears
    function automatic int model_lat(input logic [7:0] x, input logic [3:0] y);
        return model_early(x, y) ? 1 : 9;
    endfunction

    function automatic int model_busy(input logic [7:0] x, input logic [3:0] y);
        return model_early(x, y) ? 0 : 8;
    endfunction

    // ---------------- stimulus driver ----------------
    // Issues one operation and watches it to completion. Samples 1 time unit
    // after each rising edge. With spam set, start is re-asserted with junk
    // operands on every cycle until done is seen.
    task automatic run_op(input logic [7:0] x, input logic [3:0] y, input bit spam,
                          output logic [8:0] q, output logic [3:0] r,
                          output int lat, output int busy_cycles,
                          output bit overlap, output bit timed_out);
        @(negedge clk);
        start = 1'b1;
        X = x;
        Y = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        X = 8'($urandom);
        Y = 4'($urandom);
        lat = 0;
        busy_cycles = 0;
        overlap = 1'b0;
        while (!done && lat < TIMEOUT) begin
            if (busy) busy_cycles++;
            if (spam) begin
                start = 1'b1;
                X = 8'($urandom);
                Y = 4'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
            start = 1'b0;
            if (busy && done) overlap = 1'b1;
        end
        timed_out = !done;
        q = Q;
        r = R;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        X = 8'd0;
        Y = 4'd0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Q !== 9'd0 || R !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b Q=%h R=%h expected 0 0 000 0",
                     busy, done, Q, R);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [7:0] dx [12] = '{8'h00, 8'hFF, 8'h00, 8'h03, 8'h20, 8'h45,
                                8'h81, 8'hD0, 8'h40, 8'h60, 8'hFF, 8'hFF};
        logic [3:0] dy [12] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd4, 4'd5,
                                4'd3, 4'd4, 4'd11, 4'd13, 4'd8, 4'd15};
        logic [8:0] eq [12] = '{9'h1FF, 9'h1FF, 9'd0, 9'd3, 9'd8, 9'd13,
                                9'd43, 9'd52, 9'd5, 9'd7, 9'd31, 9'd17};
        logic [3:0] er [12] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4,
                                4'd0, 4'd0, 4'd9, 4'd5, 4'd7, 4'd0};
        logic [8:0] q;
        logic [3:0] r;
        int lat, bc;
        bit ov, to;
        for (int i = 0; i < 12; i++) begin
            run_op(dx[i], dy[i], 1'b0, q, r, lat, bc, ov, to);
            checks++;
            if (to || q !== eq[i] || r !== er[i]) begin
                failures++;
                $display("FAIL directed_result %h/%h: Q=%h R=%h timeout=%b expected Q=%h R=%h",
                         dx[i], dy[i], q, r, to, eq[i], er[i]);
            end
            checks++;
            if (lat != model_lat(dx[i], dy[i]) || bc != model_busy(dx[i], dy[i]) || ov) begin
                failures++;
                $display("FAIL directed_timing %h/%h: latency=%0d busy_cycles=%0d overlap=%b expected %0d %0d 0",
                         dx[i], dy[i], lat, bc, ov, model_lat(dx[i], dy[i]), model_busy(dx[i], dy[i]));
            end
        end
    endtask

    task automatic test_sweep();
        logic [8:0] q;
        logic [3:0] r;
        int lat, bc;
        bit ov, to;
        int bad = 0;
        for (int xi = 0; xi < 256; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                run_op(8'(xi), 4'(yi), 1'b0, q, r, lat, bc, ov, to);
                checks++;
                if (to || q !== model_q(8'(xi), 4'(yi)) || r !== model_r(8'(xi), 4'(yi))
                    || lat != model_lat(8'(xi), 4'(yi)) || ov) begin
                    failures++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL sweep %0d/%0d: Q=%h R=%h latency=%0d expected Q=%h R=%h latency=%0d",
                                 xi, yi, q, r, lat, model_q(8'(xi), 4'(yi)),
                                 model_r(8'(xi), 4'(yi)), model_lat(8'(xi), 4'(yi)));
                end
            end
        end
    endtask

    task automatic test_handshake();
        logic [8:0] q;
        logic [3:0] r;
        int lat, bc;
        bit ov, to;
        logic [7:0] x;
        logic [3:0] y;
        for (int n = 0; n < 4; n++) begin
            // non-trivial operands so the iterations run in either build
            y = 4'($urandom_range(1, 15));
            x = 8'($urandom_range(int'(y), 255));
            run_op(x, y, 1'b1, q, r, lat, bc, ov, to);
            checks++;
            if (to || q !== model_q(x, y) || r !== model_r(x, y) || lat != model_lat(x, y)) begin
                failures++;
                $display("FAIL start_ignored %h/%h: Q=%h R=%h latency=%0d expected Q=%h R=%h latency=%0d",
                         x, y, q, r, lat, model_q(x, y), model_r(x, y), model_lat(x, y));
            end
            // done lasts one cycle, then Q/R hold with no new start
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_width: done=%b one cycle after pulse, expected 0", done);
            end
            for (int k = 0; k < 5; k++) begin
                X = 8'($urandom);
                Y = 4'($urandom);
                @(posedge clk);
                #1;
                checks++;
                if (Q !== model_q(x, y) || R !== model_r(x, y) || done !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL result_hold: Q=%h R=%h done=%b busy=%b expected Q=%h R=%h 0 0",
                             Q, R, done, busy, model_q(x, y), model_r(x, y));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] q;
        logic [3:0] r;
        int lat, bc;
        bit ov, to;
        logic [7:0] x;
        logic [3:0] y;
        // each run_op re-issues start on the cycle right after done,
        // i.e. sampled at edge N+10 of the previous operation
        for (int n = 0; n < 40; n++) begin
            x = 8'($urandom);
            y = 4'($urandom);
            run_op(x, y, 1'b0, q, r, lat, bc, ov, to);
            checks++;
            if (to || q !== model_q(x, y) || r !== model_r(x, y) || lat != model_lat(x, y)
                || bc != model_busy(x, y) || ov) begin
                failures++;
                $display("FAIL back_to_back %h/%h: Q=%h R=%h latency=%0d busy_cycles=%0d expected Q=%h R=%h latency=%0d busy_cycles=%0d",
                         x, y, q, r, lat, bc, model_q(x, y), model_r(x, y),
                         model_lat(x, y), model_busy(x, y));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [8:0] q;
        logic [3:0] r;
        int lat, bc;
        bit ov, to;
        int seen_done = 0;
        // leave a nonzero result on the outputs first
        run_op(8'h45, 4'd5, 1'b0, q, r, lat, bc, ov, to);
        @(negedge clk);
        start = 1'b1;
        X = 8'hC7;
        Y = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || Q !== 9'd13 || R !== 4'd4) begin
            failures++;
            $display("FAIL pre_reset: busy=%b Q=%h R=%h expected busy=1 Q=00d R=4", busy, Q, R);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Q !== 9'd0 || R !== 4'd0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b Q=%h R=%h expected 0 0 000 0",
                     busy, done, Q, R);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done != 0 || Q !== 9'd0 || R !== 4'd0) begin
            failures++;
            $display("FAIL aborted_run: activity_cycles=%0d Q=%h R=%h expected 0 000 0",
                     seen_done, Q, R);
        end
        run_op(8'hC7, 4'd3, 1'b0, q, r, lat, bc, ov, to);
        checks++;
        if (to || q !== model_q(8'hC7, 4'd3) || r !== model_r(8'hC7, 4'd3)) begin
            failures++;
            $display("FAIL after_reset_op: Q=%h R=%h expected Q=%h R=%h",
                     q, r, model_q(8'hC7, 4'd3), model_r(8'hC7, 4'd3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
